adc_spi_xfer: RTL and testbench

//  3-wire SPI register master for the on-board ADC (16-bit instruction + 8-bit data, shared SDIO).

---
 rtl/adc_spi_pkg.sv | 34 +++
 rtl/spi_bit_timer.sv | 79 +++++++
 rtl/adc_spi_xfer.sv | 200 ++++++++++++++++++++
 tb/tb_adc_spi_xfer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the 3-wire ADC register master.
// Contents:
//   xfer_state_t  - transfer FSM states
//   INST_BITS / DATA_BITS / FRAME_BITS - frame geometry (16 + 8 bits)
//   RW_READ       - value of the rw bit that selects a register read
//   W_ONE_BYTE    - W1:W0 field meaning "one data byte follows"
//   build_frame() - assembles the 24-bit MSB-first frame
package adc_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        INST,
        DATA,
        HOLD,
        GAP
    } xfer_state_t;

    localparam int         INST_BITS  = 16;
    localparam int         DATA_BITS  = 8;
    localparam int         FRAME_BITS = INST_BITS + DATA_BITS;
    localparam logic       RW_READ    = 1'b1;
    localparam logic [1:0] W_ONE_BYTE = 2'b00;

    // {rw, W1:W0, addr[12:0], data[7:0]}, transmitted MSB first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 rw,
        input logic [12:0]          addr,
        input logic [DATA_BITS-1:0] wdata
    );
        return {rw, W_ONE_BYTE, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Bit-phase timer for the SPI master. While run_i is high it walks through
// FRAME_BITS bits, each made of a low phase and a high phase of CLK_DIV clk
// cycles. All counters sit at zero whenever run_i is low, so a frame always
// starts at bit 0, low phase, divider 0.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   run_i           - high while the frame is shifting (INST/DATA states)
//   rise_tick_o     - last clk of a low phase (sclk goes high at the next edge)
//   fall_tick_o     - last clk of a high phase (sclk goes low, bit ends)
//   sample_tick_o   - clk in which the incoming bit is captured
//   bit_idx_o       - index of the current bit, 0..FRAME_BITS-1
//   last_bit_o      - current bit is the final bit of the frame
module spi_bit_timer
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    output logic       rise_tick_o,
    output logic       fall_tick_o,
    output logic       sample_tick_o,
    output logic [4:0] bit_idx_o,
    output logic       last_bit_o
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [4:0]    BIT_LAST = 5'(FRAME_BITS - 1);

    logic [DW-1:0] div_q, div_d;
    logic          phase_q, phase_d;    // 0 = low phase, 1 = high phase
    logic [4:0]    bit_q, bit_d;
    logic          div_end;

    assign div_end       = (div_q == DIV_LAST);
    assign rise_tick_o   = run_i && !phase_q && div_end;
    assign fall_tick_o   = run_i && phase_q && div_end;
    // The input flop already delays sdio by one clk, so capturing at the end
    // of the high phase takes the value present during the high phase.
    assign sample_tick_o = fall_tick_o;
    assign bit_idx_o     = bit_q;
    assign last_bit_o    = (bit_q == BIT_LAST);

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        if (!run_i) begin
            div_d   = '0;
            phase_d = 1'b0;
            bit_d   = '0;
        end else if (div_end) begin
            div_d   = '0;
            phase_d = !phase_q;
            if (phase_q) begin
                // End of a bit; return to 0 after the last one so nothing
                // keeps counting once the frame is over.
                bit_d = last_bit_o ? 5'd0 : bit_q + 5'd1;
            end
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: rtl/adc_spi_xfer.sv
// 3-wire SPI register master for the on-board ADC: one 16-bit instruction
// followed by one data byte on a shared SDIO line. Performs single-byte
// register reads and writes.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  - request handshake (accepted when both high)
//   req_rw_i                 - 1 = read, 0 = write
//   req_addr_i, req_wdata_i  - register address / write data
//   rsp_valid_o              - one-clk pulse when a transfer finishes
//   rsp_rdata_o              - read data (0 after a write), held until next rsp
//   sclk_o, csb_o            - SPI clock (idles low) and chip select (active low)
//   sdio_o, sdio_oe_o, sdio_i- SDIO drive value, drive enable, pin value
// Response latency from the accepting edge: CS_SETUP + 48*CLK_DIV + CS_HOLD + 1.
module adc_spi_xfer
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rw_i,
    input  logic [12:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic        sclk_o,
    output logic        csb_o,
    output logic        sdio_o,
    output logic        sdio_oe_o,
    input  logic        sdio_i
);

    localparam int            CW         = 16;
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    // HOLD runs one clk longer than CS_HOLD; that extra clk lets the last
    // sampled bit settle before it is published on rsp_rdata.
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
    localparam logic [4:0]    INST_LAST  = 5'(INST_BITS - 1);

    xfer_state_t            state_q;
    logic [CW-1:0]          cnt_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [DATA_BITS-1:0]   rx_q;
    logic                   rw_q;
    logic                   sdio_in_q;
    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic [DATA_BITS-1:0]   rsp_rdata_q;
    logic                   sclk_q;
    logic                   csb_q;
    logic                   sdio_o_q;
    logic                   sdio_oe_q;

    logic       run;
    logic       rise_tick;
    logic       fall_tick;
    logic       sample_tick;
    logic [4:0] bit_idx;
    logic       last_bit;

    assign run = (state_q == INST) || (state_q == DATA);

    spi_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .run_i         (run),
        .rise_tick_o   (rise_tick),
        .fall_tick_o   (fall_tick),
        .sample_tick_o (sample_tick),
        .bit_idx_o     (bit_idx),
        .last_bit_o    (last_bit)
    );

    // Input flop on the pin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sdio_in_q <= 1'b0;
        end else begin
            sdio_in_q <= sdio_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rx_q        <= '0;
            rw_q        <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            sclk_q      <= 1'b0;
            csb_q       <= 1'b1;
            sdio_o_q    <= 1'b0;
            sdio_oe_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        state_q     <= SETUP;
                        req_ready_q <= 1'b0;
                        csb_q       <= 1'b0;
                        sdio_oe_q   <= 1'b1;
                        rw_q        <= req_rw_i;
                        shift_q     <= build_frame(req_rw_i, req_addr_i, req_wdata_i);
                        rx_q        <= '0;
                        cnt_q       <= '0;
                    end
                end

                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        // First bit goes out as the low phase of bit 0 begins.
                        state_q  <= INST;
                        sdio_o_q <= shift_q[FRAME_BITS-1];
                        shift_q  <= {shift_q[FRAME_BITS-2:0], 1'b0};
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                INST, DATA: begin
                    if (rise_tick) begin
                        sclk_q <= 1'b1;
                    end
                    if (sample_tick && (state_q == DATA) && (rw_q == RW_READ)) begin
                        rx_q <= {rx_q[DATA_BITS-2:0], sdio_in_q};
                    end
                    if (fall_tick) begin
                        sclk_q <= 1'b0;
                        if (last_bit) begin
                            state_q   <= HOLD;
                            sdio_o_q  <= 1'b0;
                            sdio_oe_q <= 1'b0;
                            cnt_q     <= '0;
                        end else begin
                            sdio_o_q <= shift_q[FRAME_BITS-1];
                            shift_q  <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            if (bit_idx == INST_LAST) begin
                                state_q <= DATA;
                                // Turn the line around for the ADC before
                                // data bit 7's low phase starts.
                                if (rw_q == RW_READ) begin
                                    sdio_oe_q <= 1'b0;
                                end
                            end
                        end
                    end
                end

                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q     <= GAP;
                        csb_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (rw_q == RW_READ) ? rx_q : '0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign sclk_o      = sclk_q;
    assign csb_o       = csb_q;
    assign sdio_o      = sdio_o_q;
    assign sdio_oe_o   = sdio_oe_q;

endmodule

// File: tb/tb_adc_spi_xfer.sv
// Directed bench for adc_spi_xfer. Instance a: CLK_DIV=2, CS_SETUP=2,
// CS_HOLD=2, CS_GAP=4 (latency 101). Instance b: CLK_DIV=1, CS_SETUP=1,
// CS_HOLD=1, CS_GAP=4 (latency 51). Each instance has a small ADC model that
// records sdio_o/sdio_oe at every sclk rise and drives read data on sclk falls.
module tb_adc_spi_xfer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- instance a ----------------
    logic        a_req_valid = 1'b0, a_req_ready, a_req_rw = 1'b0;
    logic [12:0] a_req_addr = '0;
    logic [7:0]  a_req_wdata = '0;
    logic        a_rsp_valid;
    logic [7:0]  a_rsp_rdata;
    logic        a_sclk, a_csb, a_sdio_o, a_sdio_oe;
    logic        a_sdio_i = 1'b0;

    adc_spi_xfer #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_rw_i(a_req_rw),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata),
        .sclk_o(a_sclk), .csb_o(a_csb), .sdio_o(a_sdio_o), .sdio_oe_o(a_sdio_oe),
        .sdio_i(a_sdio_i)
    );

    // ---------------- instance b ----------------
    logic        b_req_valid = 1'b0, b_req_ready, b_req_rw = 1'b0;
    logic [12:0] b_req_addr = '0;
    logic [7:0]  b_req_wdata = '0;
    logic        b_rsp_valid;
    logic [7:0]  b_rsp_rdata;
    logic        b_sclk, b_csb, b_sdio_o, b_sdio_oe;
    logic        b_sdio_i = 1'b0;

    adc_spi_xfer #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_rw_i(b_req_rw),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
        .sclk_o(b_sclk), .csb_o(b_csb), .sdio_o(b_sdio_o), .sdio_oe_o(b_sdio_oe),
        .sdio_i(b_sdio_i)
    );

    // ---------------- ADC model a ----------------
    int          a_rises = 0, a_frames = 0, a_rsp_cnt = 0, a_gap = 0;
    logic [23:0] a_cap = '0, a_oe = '0, a_last = '0;
    logic [7:0]  a_adc_data = '0;
    time         a_t_rise = 0;

    always @(negedge a_csb) begin
        a_rises = 0; a_cap = '0; a_oe = '0; a_frames++;
        if (a_t_rise != 0) a_gap = int'(($time - a_t_rise) / 10);
    end
    always @(posedge a_csb) begin
        a_last = a_cap; a_t_rise = $time; a_sdio_i = 1'b0;
    end
    always @(posedge a_sclk) if (!a_csb) begin
        a_cap = {a_cap[22:0], a_sdio_o}; a_oe = {a_oe[22:0], a_sdio_oe}; a_rises++;
    end
    always @(negedge a_sclk) if (!a_csb && a_rises >= 16 && a_rises < 24)
        a_sdio_i = a_adc_data[3'(23 - a_rises)];
    always @(negedge clk) if (a_rsp_valid) a_rsp_cnt++;

    // ---------------- ADC model b ----------------
    int          b_rises = 0;
    logic [23:0] b_cap = '0, b_oe = '0;
    logic [7:0]  b_adc_data = '0;
    time         b_t_first = 0, b_t_last = 0;

    always @(negedge b_csb) begin
        b_rises = 0; b_cap = '0; b_oe = '0;
    end
    always @(posedge b_csb) b_sdio_i = 1'b0;
    always @(posedge b_sclk) if (!b_csb) begin
        b_cap = {b_cap[22:0], b_sdio_o}; b_oe = {b_oe[22:0], b_sdio_oe};
        if (b_rises == 0) b_t_first = $time;
        b_t_last = $time;
        b_rises++;
    end
    always @(negedge b_sclk) if (!b_csb && b_rises >= 16 && b_rises < 24)
        b_sdio_i = b_adc_data[3'(23 - b_rises)];

    // ---------------- transfer helpers ----------------
    // lat = number of clk edges from the accepting edge to the one that
    // raised rsp_valid (1000 means it never came).
    task automatic a_xfer(input logic rw, input logic [12:0] addr, input logic [7:0] wd,
                          output int lat);
        int n;
        @(negedge clk);
        a_req_rw = rw; a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1;
        n = 0;
        while (!a_req_ready && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk); #1 a_req_valid = 1'b0;
        lat = 0;
        while (lat < 1000) begin
            @(negedge clk);
            if (a_rsp_valid) break;
            lat++;
        end
        $display("xfer a rw=%0d addr=%h wdata=%h lat=%0d rdata=%h", rw, addr, wd, lat, a_rsp_rdata);
    endtask

    task automatic b_xfer(input logic rw, input logic [12:0] addr, input logic [7:0] wd,
                          output int lat);
        int n;
        @(negedge clk);
        b_req_rw = rw; b_req_addr = addr; b_req_wdata = wd; b_req_valid = 1'b1;
        n = 0;
        while (!b_req_ready && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk); #1 b_req_valid = 1'b0;
        lat = 0;
        while (lat < 1000) begin
            @(negedge clk);
            if (b_rsp_valid) break;
            lat++;
        end
        $display("xfer b rw=%0d addr=%h wdata=%h lat=%0d rdata=%h", rw, addr, wd, lat, b_rsp_rdata);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (a_csb !== 1'b1) begin n_bad++; $display("FAIL reset_csb got=%b exp=1", a_csb); end
        n_vec++; if (a_sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk got=%b exp=0", a_sclk); end
        n_vec++; if (a_sdio_o !== 1'b0) begin n_bad++; $display("FAIL reset_sdio_o got=%b exp=0", a_sdio_o); end
        n_vec++; if (a_sdio_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got=%b exp=0", a_sdio_oe); end
        n_vec++; if (a_req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", a_req_ready); end
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        n_vec++; if (a_rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got=%h exp=00", a_rsp_rdata); end
        n_vec++; if (b_csb !== 1'b1) begin n_bad++; $display("FAIL reset_b_csb got=%b exp=1", b_csb); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (a_req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset got=%b exp=1", a_req_ready); end
    endtask

    task automatic test_write();
        int lat;
        a_xfer(1'b0, 13'h014, 8'h21, lat);
        n_vec++; if (lat !== 101) begin n_bad++; $display("FAIL wr_latency got=%0d exp=101", lat); end
        n_vec++; if (a_cap !== 24'h001421) begin n_bad++; $display("FAIL wr_frame got=%h exp=001421", a_cap); end
        n_vec++; if (a_rises !== 24) begin n_bad++; $display("FAIL wr_rises got=%0d exp=24", a_rises); end
        n_vec++; if (a_oe !== 24'hFFFFFF) begin n_bad++; $display("FAIL wr_oe got=%h exp=ffffff", a_oe); end
        n_vec++; if (a_rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL wr_rdata got=%h exp=00", a_rsp_rdata); end
        n_vec++; if (a_csb !== 1'b1) begin n_bad++; $display("FAIL wr_csb_end got=%b exp=1", a_csb); end
        @(negedge clk);
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_pulse got=%b exp=0", a_rsp_valid); end
    endtask

    task automatic test_read();
        int lat;
        a_adc_data = 8'h88;
        a_xfer(1'b1, 13'h001, 8'hFF, lat);
        n_vec++; if (lat !== 101) begin n_bad++; $display("FAIL rd_latency got=%0d exp=101", lat); end
        n_vec++; if (a_cap[23:8] !== 16'h8001) begin n_bad++; $display("FAIL rd_inst got=%h exp=8001", a_cap[23:8]); end
        n_vec++; if (a_oe !== 24'hFFFF00) begin n_bad++; $display("FAIL rd_oe got=%h exp=ffff00", a_oe); end
        n_vec++; if (a_rsp_rdata !== 8'h88) begin n_bad++; $display("FAIL rd_rdata got=%h exp=88", a_rsp_rdata); end
        repeat (3) @(negedge clk);
        n_vec++; if (a_rsp_rdata !== 8'h88) begin n_bad++; $display("FAIL rd_rdata_hold got=%h exp=88", a_rsp_rdata); end
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_pulse got=%b exp=0", a_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int n, f0, r0;
        f0 = a_frames; r0 = a_rsp_cnt;
        @(negedge clk);
        a_req_rw = 1'b0; a_req_addr = 13'h0AA; a_req_wdata = 8'h5C; a_req_valid = 1'b1;
        n = 0;
        while (a_req_ready && n < 50) begin @(negedge clk); n++; end
        // First request taken: present the second one while valid stays high.
        a_req_addr = 13'h1F0; a_req_wdata = 8'hE7;
        n = 0;
        while (!a_rsp_valid && n < 1000) begin @(negedge clk); n++; end
        $display("xfer a b2b#1 addr=0aa rsp=%b rdata=%h", a_rsp_valid, a_rsp_rdata);
        n_vec++; if (a_last !== 24'h00AA5C) begin n_bad++; $display("FAIL b2b_frame1 got=%h exp=00aa5c", a_last); end
        n_vec++; if (a_rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL b2b_rdata_clear got=%h exp=00", a_rsp_rdata); end
        n = 0;
        while (!a_req_ready && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (a_req_ready && n < 100) begin @(negedge clk); n++; end
        a_req_valid = 1'b0;
        n = 0;
        while (!a_rsp_valid && n < 1000) begin @(negedge clk); n++; end
        $display("xfer a b2b#2 addr=1f0 rsp=%b rdata=%h", a_rsp_valid, a_rsp_rdata);
        n_vec++; if (a_last !== 24'h01F0E7) begin n_bad++; $display("FAIL b2b_frame2 got=%h exp=01f0e7", a_last); end
        n_vec++; if (a_gap < 5) begin n_bad++; $display("FAIL b2b_gap got=%0d exp>=5", a_gap); end
        repeat (30) @(negedge clk);
        n_vec++; if (a_frames !== f0 + 2) begin n_bad++; $display("FAIL b2b_frames got=%0d exp=%0d", a_frames, f0 + 2); end
        n_vec++; if (a_rsp_cnt !== r0 + 2) begin n_bad++; $display("FAIL b2b_rsps got=%0d exp=%0d", a_rsp_cnt, r0 + 2); end
    endtask

    task automatic test_busy_request();
        int n, f0, r0;
        f0 = a_frames; r0 = a_rsp_cnt;
        @(negedge clk);
        a_req_rw = 1'b0; a_req_addr = 13'h055; a_req_wdata = 8'hA5; a_req_valid = 1'b1;
        n = 0;
        while (a_req_ready && n < 50) begin @(negedge clk); n++; end
        a_req_valid = 1'b0;
        repeat (60) @(negedge clk);
        a_req_rw = 1'b1; a_req_addr = 13'h123; a_req_valid = 1'b1;
        n_vec++; if (a_req_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready got=%b exp=0", a_req_ready); end
        @(negedge clk);
        a_req_valid = 1'b0;
        n = 0;
        while (!a_rsp_valid && n < 1000) begin @(negedge clk); n++; end
        $display("xfer a busy addr=055 rsp=%b rdata=%h", a_rsp_valid, a_rsp_rdata);
        n_vec++; if (a_last !== 24'h0055A5) begin n_bad++; $display("FAIL busy_frame got=%h exp=0055a5", a_last); end
        repeat (30) @(negedge clk);
        n_vec++; if (a_frames !== f0 + 1) begin n_bad++; $display("FAIL busy_frames got=%0d exp=%0d", a_frames, f0 + 1); end
        n_vec++; if (a_rsp_cnt !== r0 + 1) begin n_bad++; $display("FAIL busy_rsps got=%0d exp=%0d", a_rsp_cnt, r0 + 1); end
    endtask

    task automatic test_reset_mid_data();
        int n, r0, lat;
        r0 = a_rsp_cnt;
        @(negedge clk);
        a_req_rw = 1'b0; a_req_addr = 13'h033; a_req_wdata = 8'h99; a_req_valid = 1'b1;
        n = 0;
        while (a_req_ready && n < 50) begin @(negedge clk); n++; end
        a_req_valid = 1'b0;
        n = 0;
        while (a_rises < 18 && n < 500) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (a_csb !== 1'b1) begin n_bad++; $display("FAIL midrst_csb got=%b exp=1", a_csb); end
        n_vec++; if (a_sclk !== 1'b0) begin n_bad++; $display("FAIL midrst_sclk got=%b exp=0", a_sclk); end
        n_vec++; if (a_sdio_oe !== 1'b0) begin n_bad++; $display("FAIL midrst_oe got=%b exp=0", a_sdio_oe); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        $display("xfer a aborted addr=033 rsps=%0d", a_rsp_cnt - r0);
        n_vec++; if (a_rsp_cnt !== r0) begin n_bad++; $display("FAIL midrst_no_rsp got=%0d exp=%0d", a_rsp_cnt, r0); end
        a_xfer(1'b0, 13'h044, 8'h3C, lat);
        n_vec++; if (lat !== 101) begin n_bad++; $display("FAIL postrst_latency got=%0d exp=101", lat); end
        n_vec++; if (a_cap !== 24'h00443C) begin n_bad++; $display("FAIL postrst_frame got=%h exp=00443c", a_cap); end
    endtask

    task automatic test_fast_read();
        int lat;
        b_adc_data = 8'h5A;
        b_xfer(1'b1, 13'h0FF, 8'h00, lat);
        n_vec++; if (lat !== 51) begin n_bad++; $display("FAIL fast_latency got=%0d exp=51", lat); end
        n_vec++; if (b_cap[23:8] !== 16'h80FF) begin n_bad++; $display("FAIL fast_inst got=%h exp=80ff", b_cap[23:8]); end
        n_vec++; if (b_rsp_rdata !== 8'h5A) begin n_bad++; $display("FAIL fast_rdata got=%h exp=5a", b_rsp_rdata); end
        n_vec++; if (b_rises !== 24) begin n_bad++; $display("FAIL fast_rises got=%0d exp=24", b_rises); end
        n_vec++; if (b_t_last - b_t_first !== 460) begin n_bad++; $display("FAIL fast_sclk_period got=%0t exp=460", b_t_last - b_t_first); end
        n_vec++; if (b_oe !== 24'hFFFF00) begin n_bad++; $display("FAIL fast_oe got=%h exp=ffff00", b_oe); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_request();
        test_reset_mid_data();
        test_fast_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
